// File: rtl/patch_serializer_pkg.sv
// -----------------------------------------------------------------------------
// patch_serializer_pkg
// Shared definitions for the patch serializer: pixel/channel/kernel sizes,
// bit-offset helpers for the window word and the packed 3x3 patch, the emitter
// state encoding, and the channel-mask search helpers used by the emitter.
// Optional feature macro used by the files that import this package:
//   PATCH_ZERO_SKIP_EN
// -----------------------------------------------------------------------------
package patch_serializer_pkg;

    localparam int DW      = 16;            // bits per pixel
    localparam int NCH     = 4;             // channels per window word
    localparam int K       = 3;             // kernel size (matches 3-row window)
    localparam int CH_W    = 2;             // channel index width
    localparam int CNT_W   = 5;             // column/row counter width
    localparam int WIN_W   = NCH * K * DW;  // 192-bit window word
    localparam int PATCH_W = K * K * DW;    // 144-bit packed patch

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } emit_state_e;

    // Offset of window row (0 = top/oldest image row) of channel ch in WIN.
    function automatic int win_off(input int ch, input int row);
        return ch * K * DW + row * DW;
    endfunction

    // Offset of patch pixel (row 0..2 top->bottom, col 0..2 old->new).
    function automatic int patch_off(input int row, input int col);
        return DW * (K * col + row);
    endfunction

    // Lowest channel index >= start whose mask bit is set; bit 2 = found.
    function automatic logic [2:0] first_from(input logic [NCH-1:0] mask,
                                              input logic [2:0]     start);
        logic [2:0] res;
        res = 3'b000;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k] && (k >= int'(start))) begin
                res = {1'b1, 2'(k)};
            end
        end
        return res;
    endfunction

    // True when some channel above idx still has to be presented.
    function automatic logic has_after(input logic [NCH-1:0]  mask,
                                       input logic [CH_W-1:0] idx);
        logic found;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (mask[k] && (k > int'(idx))) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/patch_pack.sv
// -----------------------------------------------------------------------------
// patch_pack
// Combinational gather of one channel's 3x3 patch from three window columns.
// Ports:
//   col_old_i / col_mid_i / col_new_i : window words, oldest to newest column
//   ch_i                              : channel to gather
//   patch_o                           : pixel(i,j) at [16*(3j+i) +: 16]
//   zero_o (PATCH_ZERO_SKIP_EN only)  : all nine pixels are zero
// -----------------------------------------------------------------------------
module patch_pack
    import patch_serializer_pkg::*;
(
    input  logic [WIN_W-1:0]   col_old_i,
    input  logic [WIN_W-1:0]   col_mid_i,
    input  logic [WIN_W-1:0]   col_new_i,
    input  logic [CH_W-1:0]    ch_i,
    output logic [PATCH_W-1:0] patch_o
`ifdef PATCH_ZERO_SKIP_EN
    ,
    output logic               zero_o
`endif
);

    logic [K-1:0][WIN_W-1:0] cols_s;

    assign cols_s = {col_new_i, col_mid_i, col_old_i};

    // Window row i of column j lands at patch position (i,j).
    always_comb begin
        patch_o = '0;
        for (int j = 0; j < K; j++) begin
            for (int i = 0; i < K; i++) begin
                patch_o[patch_off(i, j) +: DW] = cols_s[j][win_off(int'(ch_i), i) +: DW];
            end
        end
    end

`ifdef PATCH_ZERO_SKIP_EN
    assign zero_o = ~|patch_o;
`endif

endmodule

// File: rtl/patch_serializer.sv
// -----------------------------------------------------------------------------
// patch_serializer
// Captures the 3-row x 4-channel window one cycle after in_valid_i, keeps a
// 3-column history, forms a 3x3 patch per channel and presents the patches
// one channel per cycle on a valid/ready interface.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   in_valid_i, win_i      : line-buffer strobe; window valid on win_i next cycle
//   depth_i, height_i      : image width-1 / height-1
//   out_valid_o/out_ready_i: patch handshake
//   out_data_o, out_ch_o   : packed 3x3 patch and its channel
//   out_last_o             : last patch of the frame
//   overflow_o             : sticky, a valid patch was dropped
// Optional feature: PATCH_ZERO_SKIP_EN skips channels whose patch is all zero.
// -----------------------------------------------------------------------------
module patch_serializer
    import patch_serializer_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    input  logic [WIN_W-1:0]   win_i,
    input  logic [CNT_W-1:0]   depth_i,
    input  logic [CNT_W-1:0]   height_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [PATCH_W-1:0] out_data_o,
    output logic [CH_W-1:0]    out_ch_o,
    output logic               out_last_o,
    output logic               overflow_o
);

    // Only the two older columns are stored; the newest is win_i itself
    // during the capture cycle, so a patch is formed as the column arrives.
    logic                      cap_v_q;
    logic [WIN_W-1:0]          hist_old_q, hist_mid_q;
    logic [CNT_W-1:0]          col_q, row_q;

    emit_state_e               state_q, state_d;
    logic [NCH-1:0][PATCH_W-1:0] snap_q, snap_d;
    logic [NCH-1:0]            mask_q, mask_d;
    logic                      last_col_q, last_col_d;
    logic                      out_valid_q, out_valid_d;
    logic [PATCH_W-1:0]        out_data_q, out_data_d;
    logic [CH_W-1:0]           out_ch_q, out_ch_d;
    logic                      out_last_q, out_last_d;
    logic                      overflow_q, overflow_d;

    logic [NCH-1:0][PATCH_W-1:0] pack_s;
    logic [NCH-1:0]            mask_new_s;
    logic [2:0]                first_new_s, next_s;
    logic                      patch_ok_s, last_col_s, hs_s, free_s, load_s, drop_s;

`ifdef PATCH_ZERO_SKIP_EN
    logic [NCH-1:0]            zero_s;
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        patch_pack u_pack (
            .col_old_i (hist_old_q),
            .col_mid_i (hist_mid_q),
            .col_new_i (win_i),
            .ch_i      (CH_W'(g)),
            .patch_o   (pack_s[g])
`ifdef PATCH_ZERO_SKIP_EN
            ,
            .zero_o    (zero_s[g])
`endif
        );
    end

`ifdef PATCH_ZERO_SKIP_EN
    assign mask_new_s = ~zero_s;
`else
    assign mask_new_s = {NCH{1'b1}};
`endif

    // Position tests use the counters before they advance for this column.
    assign patch_ok_s  = cap_v_q && (col_q >= 5'd2) && (row_q >= 5'd2);
    assign last_col_s  = (col_q == depth_i) && (row_q == height_i);
    assign first_new_s = first_from(mask_new_s, 3'd0);
    assign next_s      = first_from(mask_q, {1'b0, out_ch_q} + 3'd1);
    assign hs_s        = out_valid_q && out_ready_i;
    // The final handshake of a patch frees the emitter in the same cycle.
    assign free_s      = (state_q == ST_IDLE) || (hs_s && !next_s[2]);
    assign load_s      = patch_ok_s && free_s && first_new_s[2];
    assign drop_s      = patch_ok_s && !free_s && first_new_s[2];

    // Capture strobe delay, column history shift and column/row counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_v_q    <= 1'b0;
            hist_old_q <= '0;
            hist_mid_q <= '0;
            col_q      <= 5'd0;
            row_q      <= 5'd0;
        end else begin
            cap_v_q <= in_valid_i;
            if (cap_v_q) begin
                hist_old_q <= hist_mid_q;
                hist_mid_q <= win_i;
                if (col_q == depth_i) begin
                    col_q <= 5'd0;
                    row_q <= (row_q == height_i) ? 5'd0 : row_q + 5'd1;
                end else begin
                    col_q <= col_q + 5'd1;
                end
            end
        end
    end

    // Emitter next state: step through the snapshot, reload on a free slot.
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        mask_d      = mask_q;
        last_col_d  = last_col_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        overflow_d  = overflow_q;
        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
            ST_EMIT: begin
                if (hs_s && next_s[2]) begin
                    out_ch_d   = next_s[1:0];
                    out_data_d = snap_q[next_s[1:0]];
                    out_last_d = last_col_q && !has_after(mask_q, next_s[1:0]);
                end else if (hs_s) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
        if (load_s) begin
            state_d     = ST_EMIT;
            snap_d      = pack_s;
            mask_d      = mask_new_s;
            last_col_d  = last_col_s;
            out_valid_d = 1'b1;
            out_ch_d    = first_new_s[1:0];
            out_data_d  = pack_s[first_new_s[1:0]];
            out_last_d  = last_col_s && !has_after(mask_new_s, first_new_s[1:0]);
        end else if (drop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Emitter and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            snap_q      <= '0;
            mask_q      <= '0;
            last_col_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= 2'd0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            mask_q      <= mask_d;
            last_col_q  <= last_col_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;
    assign out_last_o  = out_last_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_patch_serializer.sv
// -----------------------------------------------------------------------------
// tb_patch_serializer
// Directed bench for patch_serializer with a 4x4 image (DEPTH=3, HEIGHT=3).
// Pixel value encodes channel, image row, image column and a frame salt so
// every patch position is distinguishable.
// -----------------------------------------------------------------------------
module tb_patch_serializer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [191:0] win;
    logic [4:0]   depth, height;
    logic         out_valid, out_ready, out_last, overflow;
    logic [143:0] out_data;
    logic [1:0]   out_ch;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int first_v;

    logic [143:0] got_data[$];
    logic [1:0]   got_ch[$];
    logic         got_last[$];
    int           got_cyc[$];
    int           iv_cyc[$];
    logic [143:0] exp_data[$];
    logic [1:0]   exp_ch[$];
    logic         exp_last[$];

    patch_serializer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .win_i       (win),
        .depth_i     (depth),
        .height_i    (height),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_ch_o    (out_ch),
        .out_last_o  (out_last),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] img(input int ch, input int y, input int x, input int salt);
        return 16'(ch * 4096 + (y + 2) * 64 + salt * 8 + x + 1);
    endfunction

    // Window word for column n of a 4x4 frame.
    function automatic logic [191:0] window_of(input int n, input int salt);
        logic [191:0] w;
        int c, r;
        c = n % 4;
        r = (n / 4) % 4;
        w = '0;
        for (int ch = 0; ch < 4; ch++)
            for (int i = 0; i < 3; i++)
                w[48 * ch + 16 * i +: 16] = img(ch, r - 2 + i, c, salt);
        return w;
    endfunction

    function automatic logic [143:0] patch_of(input int c, input int r, input int ch, input int salt);
        logic [143:0] p;
        p = '0;
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < 3; i++)
                p[16 * (3 * j + i) +: 16] = img(ch, r - 2 + i, c - 2 + j, salt);
        return p;
    endfunction

    task automatic build_exp(input int salt);
        exp_data.delete(); exp_ch.delete(); exp_last.delete();
        for (int n = 0; n < 16; n++) begin
            if ((n % 4) >= 2 && (n / 4) >= 2) begin
                for (int ch = 0; ch < 4; ch++) begin
                    exp_data.push_back(patch_of(n % 4, n / 4, ch, salt));
                    exp_ch.push_back(2'(ch));
                    exp_last.push_back((n == 15) && (ch == 3));
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; win = '0; out_ready = 1'b0;
        depth = 5'd3; height = 5'd3;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // IN_VALID every `period` cycles; the window follows one cycle later.
    task automatic drive_stream(input int period, input int ncols, input int salt);
        int sent, last_iv;
        sent = 0; last_iv = -1;
        iv_cyc.delete();
        for (int k = 0; k < period * ncols + 2; k++) begin
            win = (last_iv >= 0) ? window_of(last_iv, salt) : '0;
            if ((k % period == 0) && (sent < ncols)) begin
                in_valid = 1'b1; iv_cyc.push_back(cyc); last_iv = sent; sent++;
            end else begin
                in_valid = 1'b0; last_iv = -1;
            end
            step();
        end
        in_valid = 1'b0; win = '0;
    endtask

    // Drives ready, records handshakes, checks hold-stability under stall.
    task automatic monitor(input int ncyc, input bit toggle);
        logic stall, pl;
        logic [143:0] pd;
        logic [1:0] pc;
        stall = 1'b0; pd = '0; pc = 2'd0; pl = 1'b0;
        first_v = -1;
        got_data.delete(); got_ch.delete(); got_last.delete(); got_cyc.delete();
        for (int k = 0; k < ncyc; k++) begin
            if (stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== pd || out_ch !== pc || out_last !== pl) begin
                    miscompares++;
                    $display("FAIL hold: cyc %0d got valid=%b ch=%0d last=%b data=%h, want valid=1 ch=%0d last=%b data=%h",
                             cyc, out_valid, out_ch, out_last, out_data, pc, pl, pd);
                end
            end
            if (out_valid && first_v < 0) first_v = cyc;
            out_ready = toggle ? cyc[0] : 1'b1;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data); got_ch.push_back(out_ch);
                got_last.push_back(out_last); got_cyc.push_back(cyc);
            end
            stall = out_valid && !out_ready;
            pd = out_data; pc = out_ch; pl = out_last;
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({out_valid, out_last, overflow, out_ch} !== 5'b0 || out_data !== 144'd0) begin
            miscompares++;
            $display("FAIL reset: got valid=%b last=%b ovf=%b ch=%0d data=%h, want all 0",
                     out_valid, out_last, overflow, out_ch, out_data);
        end
    endtask

    task automatic test_stream();
        int nlast;
        build_exp(0);
        fork
            drive_stream(4, 16, 0);
            monitor(4 * 16 + 30, 1'b0);
        join
        vectors++;
        if (got_data.size() != 16) begin
            miscompares++;
            $display("FAIL stream_count: got %0d patches, want 16", got_data.size());
        end
        nlast = 0;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (i >= got_data.size()) begin
                miscompares++;
                $display("FAIL stream_patch%0d: missing, want ch=%0d data=%h", i, exp_ch[i], exp_data[i]);
            end else begin
                if (got_last[i]) nlast++;
                if (got_data[i] !== exp_data[i] || got_ch[i] !== exp_ch[i] || got_last[i] !== exp_last[i]) begin
                    miscompares++;
                    $display("FAIL stream_patch%0d: got ch=%0d last=%b data=%h, want ch=%0d last=%b data=%h",
                             i, got_ch[i], got_last[i], got_data[i], exp_ch[i], exp_last[i], exp_data[i]);
                end
            end
        end
        vectors++;
        if (nlast != 1) begin
            miscompares++;
            $display("FAIL last_once: got %0d OUT_LAST handshakes, want 1", nlast);
        end
        vectors++;
        if (iv_cyc.size() < 11 || first_v != iv_cyc[10] + 2) begin
            miscompares++;
            $display("FAIL first_valid: got cycle %0d, want 11th IN_VALID cycle + 2", first_v);
        end
    endtask

    // Consecutive valid columns at 1 column / 4 cycles: ch3 then ch0 adjacent.
    task automatic test_back_to_back();
        build_exp(4);
        fork
            drive_stream(4, 12, 4);
            monitor(4 * 12 + 20, 1'b0);
        join
        vectors++;
        if (got_cyc.size() < 5) begin
            miscompares++;
            $display("FAIL b2b: got %0d handshakes, want at least 5", got_cyc.size());
        end else if (got_cyc[4] != got_cyc[3] + 1 || got_ch[4] !== 2'd0 || got_data[4] !== exp_data[4]) begin
            miscompares++;
            $display("FAIL b2b: got gap %0d ch=%0d data=%h, want gap 1 ch=0 data=%h",
                     got_cyc[4] - got_cyc[3], got_ch[4], got_data[4], exp_data[4]);
        end
        // finish the frame so counters wrap for the next test
        drive_stream(4, 4, 4);
        out_ready = 1'b1;
        repeat (10) step();
    endtask

    // Ready toggling; counters must have wrapped to 0 after the last frame.
    task automatic test_stall();
        build_exp(1);
        fork
            drive_stream(10, 16, 1);
            monitor(10 * 16 + 30, 1'b1);
        join
        vectors++;
        if (got_data.size() != 16) begin
            miscompares++;
            $display("FAIL stall_count: got %0d patches, want 16", got_data.size());
        end
        for (int i = 0; i < 16 && i < got_data.size(); i++) begin
            vectors++;
            if (got_data[i] !== exp_data[i] || got_ch[i] !== exp_ch[i] || got_last[i] !== exp_last[i]) begin
                miscompares++;
                $display("FAIL stall_patch%0d: got ch=%0d last=%b data=%h, want ch=%0d last=%b data=%h",
                         i, got_ch[i], got_last[i], got_data[i], exp_ch[i], exp_last[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            win = (k > 0) ? window_of(k - 1, 2) : '0;
            in_valid = 1'b1;
            step();
            vectors++;
            if (overflow !== (k >= 12)) begin
                miscompares++;
                $display("FAIL overflow_k%0d: got %b, want %b", k, overflow, (k >= 12));
            end
            if (k == 11) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== patch_of(2, 2, 0, 2)) begin
                    miscompares++;
                    $display("FAIL ovf_first: got valid=%b data=%h, want valid=1 data=%h",
                             out_valid, out_data, patch_of(2, 2, 0, 2));
                end
            end
        end
        in_valid = 1'b0;
        win = window_of(15, 2);
        step();
        win = '0;
        repeat (8) step();
        vectors++;
        if (overflow !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_sticky: got ovf=%b valid=%b, want ovf=1 valid=0", overflow, out_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        drive_stream(4, 11, 3);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== patch_of(2, 2, 0, 3)) begin
            miscompares++;
            $display("FAIL pre_reset: got valid=%b data=%h, want valid=1 data=%h",
                     out_valid, out_data, patch_of(2, 2, 0, 3));
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 144'd0 || out_ch !== 2'd0) begin
            miscompares++;
            $display("FAIL async_reset: got valid=%b ch=%0d data=%h, want all 0", out_valid, out_ch, out_data);
        end
        step();
        rst_n = 1'b1;
        step();
        build_exp(5);
        fork
            drive_stream(4, 16, 5);
            monitor(4 * 16 + 30, 1'b0);
        join
        vectors++;
        if (got_data.size() != 16) begin
            miscompares++;
            $display("FAIL post_reset_count: got %0d patches, want 16", got_data.size());
        end
        for (int i = 0; i < 16 && i < got_data.size(); i++) begin
            vectors++;
            if (got_data[i] !== exp_data[i] || got_ch[i] !== exp_ch[i] || got_last[i] !== exp_last[i]) begin
                miscompares++;
                $display("FAIL post_reset_patch%0d: got ch=%0d last=%b data=%h, want ch=%0d last=%b data=%h",
                         i, got_ch[i], got_last[i], got_data[i], exp_ch[i], exp_last[i], exp_data[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
